// File: rtl/ram_arbiter_if.sv
// Signal bundle between two RAM requesters, the arbiter and a single-port data RAM.
// master = requester/RAM side, slave = arbiter side.
interface ram_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_done;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_done;
    logic [DATA_W-1:0] m1_rdata;

    logic              ram_load;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_done, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_done, m1_rdata,
        input  ram_load, ram_addr, ram_data,
        output ram_rdata
    );

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_done, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_done, m1_rdata,
        output ram_load, ram_addr, ram_data,
        input  ram_rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port RAM with combinational read data:
// one latched command drives the RAM per ACCESS cycle, done/rdata follow a cycle later.
module ram_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15,
    parameter int RR     = 1
) (
    input  logic              clk_i,
    input  logic              reset_n_i,

    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_done_o,
    output logic [DATA_W-1:0] m0_rdata_o,

    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_done_o,
    output logic [DATA_W-1:0] m1_rdata_o,

    output logic              ram_load_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    input  logic [DATA_W-1:0] ram_data_i
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state_q, state_d;
    logic              own_q, own_d;      // 0 = port 0, 1 = port 1
    logic              last_q, last_d;    // port granted most recently
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        done_q, done_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic elig0, elig1, win;

    // A port is not eligible during its own gnt cycle, which caps each port at
    // one access per two cycles and hands the idle slot to the other port.
    assign elig0 = m0_req_i && !m0_gnt_o;
    assign elig1 = m1_req_i && !m1_gnt_o;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of process ordering.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d = IDLE;
        own_d   = own_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        win     = elig1;
        if (elig0 && elig1) begin
            win = (RR != 0) ? !last_q : 1'b0;
        end
        if (elig0 || elig1) begin
            state_d = ACCESS;
            own_d   = win;
            last_d  = win;
            we_d    = win ? m1_we_i    : m0_we_i;
            addr_d  = win ? m1_addr_i  : m0_addr_i;
            wdata_d = win ? m1_wdata_i : m0_wdata_i;
        end
    end

    always_comb begin
        m0_gnt_o   = 1'b0;
        m1_gnt_o   = 1'b0;
        ram_load_o = 1'b0;
        ram_addr_o = '0;
        ram_data_o = '0;
        if (state_q == ACCESS) begin
            m0_gnt_o   = !own_q;
            m1_gnt_o   = own_q;
            ram_load_o = we_q;
            ram_addr_o = addr_q;
            ram_data_o = wdata_q;
        end
    end

    // Response captured at the end of the ACCESS cycle; writes leave rdata alone.
    always_comb begin
        done_d   = 2'b00;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if (state_q == ACCESS) begin
            done_d[own_q] = 1'b1;
            if (!we_q) begin
                if (own_q) rdata1_d = ram_data_i;
                else       rdata0_d = ram_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            own_q    <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            done_q   <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            own_q    <= own_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            done_q   <= done_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign m0_done_o  = done_q[0];
    assign m1_done_o  = done_q[1];
    assign m0_rdata_o = rdata0_q;
    assign m1_rdata_o = rdata1_q;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the data word width.
REQ-002 The block SHALL have parameter ADDR_W, default 15, meaning the data RAM address width (32K words).
REQ-003 The block SHALL have parameter RR, default 1: 1 selects round-robin arbitration, 0 selects fixed priority with port 0 highest.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have ports m0_req_i and m1_req_i, input, 1 bit each: access request.
REQ-007 The block SHALL have ports m0_we_i and m1_we_i, input, 1 bit each: 1 = write, 0 = read.
REQ-008 The block SHALL have ports m0_addr_i and m1_addr_i, input, ADDR_W bits each: word address.
REQ-009 The block SHALL have ports m0_wdata_i and m1_wdata_i, input, DATA_W bits each: write data.
REQ-010 The block SHALL have ports m0_gnt_o and m1_gnt_o, output, 1 bit each: command accepted and driving the RAM this cycle.
REQ-011 The block SHALL have ports m0_done_o and m1_done_o, output, 1 bit each: access complete; the rdata of that port is valid.
REQ-012 The block SHALL have ports m0_rdata_o and m1_rdata_o, output, DATA_W bits each: read data of the last completed read.
REQ-013 The block SHALL have ports ram_load_o (output, 1 bit), ram_addr_o (output, ADDR_W bits) and ram_data_o (output, DATA_W bits): to the RAM load, addr and data inputs.
REQ-014 The block SHALL have port ram_data_i, input, DATA_W bits: combinational read data from the RAM.

Function
REQ-015 The FSM SHALL have two states: IDLE, meaning no RAM access, and ACCESS, meaning one latched command drives the RAM.
REQ-016 Arbitration SHALL run in every cycle that ends in IDLE or ACCESS.
  - Eligible port: req high, and gnt of that port not high in the same cycle (req is ignored during own gnt cycle).
  - Winner: at the edge, its we/addr/wdata are latched, owner is recorded, next state = ACCESS.
  - No eligible port: next state = IDLE.
REQ-017 Round-robin (RR=1): with both ports eligible, the port not granted last SHALL win; the last_grant register updates on every grant.
REQ-018 Fixed priority (RR=0): with both ports eligible, port 0 SHALL win.
REQ-019 In ACCESS, the block SHALL drive the latched command.
  - ram_addr_o and ram_data_o = latched addr and wdata.
  - ram_load_o = latched we.
  - gnt_o of the owner = 1 for exactly this cycle.
REQ-020 In IDLE, ram_load_o, ram_addr_o and ram_data_o SHALL be 0, and both gnt_o SHALL be 0.
REQ-021 At the end of each ACCESS cycle, the owner's response SHALL be registered.
  - done_o of the owner = 1 for exactly the next cycle.
  - For a read, rdata_o of the owner is loaded from ram_data_i.
  - For a write, rdata_o of the owner is unchanged.
  - rdata_o holds its value until the next read completion on that port.
REQ-022 Latency: req sampled at edge T leads to gnt high in cycle T+1 and done high in cycle T+2 (edge numbering); back-to-back ACCESS cycles SHALL be supported with no IDLE gap.
REQ-023 Throughput SHALL be one access per cycle in aggregate, and one access per 2 cycles per port.
REQ-024 A requester SHALL hold req, we, addr and wdata stable until its gnt; the block's behaviour with a command that changes before gnt is undefined.
REQ-025 Starvation: with RR=1, an eligible port SHALL be granted within 2 cycles.
REQ-026 A read following a write to the same address by either port SHALL return the new data.

Reset
REQ-027 While reset_n_i=0, asynchronously, the block SHALL clear all outputs and state.
  - State = IDLE; latched command = 0.
  - All gnt_o, done_o, rdata_o and ram_* outputs = 0.
  - last_grant = port 1, so port 0 wins the first tie.
REQ-028 Reset asserted during ACCESS SHALL abort the access: no done pulse, ram_load_o falls immediately, and no further RAM write occurs.
REQ-029 After reset_n_i rises, the first arbitration SHALL occur at the next rising edge.

Verification
REQ-030 The bench SHALL cover a single write then read: m0 writes 0x1234 to 0x0010, then reads it -> ram_load_o=1 only in the write gnt cycle, and m0_rdata_o=0x1234 with m0_done_o pulsed 2 cycles after the read req.
REQ-031 The bench SHALL cover a tie after reset: m0 and m1 request in the same cycle -> m0 granted first, m1 in the next cycle, and done pulses in consecutive cycles.
REQ-032 The bench SHALL cover continuous contention, RR=1: both ports hold req for 10 accesses -> grants alternate 0,1,0,1 and neither port waits more than 2 cycles.
REQ-033 The bench SHALL cover fixed priority, RR=0: m0 re-requests every eligible cycle -> m1 is granted only in cycles where m0 is in its gnt cycle.
REQ-034 The bench SHALL cover reset mid-write: reset_n_i=0 during the ACCESS of a write to 0x7FFF -> ram_load_o=0 immediately, no done pulse, and all outputs 0.
REQ-035 The bench SHALL cover cross-port coherence: m1 writes 0xBEEF to 0x4000, then m0 reads 0x4000 -> m0_rdata_o=0xBEEF, and m1_rdata_o is unchanged.
